// File: rtl/nearest_hit_scan_if.sv
// Scan request, sphere-table and intersection-unit signals
// bundled for the nearest-hit sphere scanner.
interface nearest_hit_scan_if #(
  parameter int ADDR_W = 4
);
  logic              start;
  logic [ADDR_W:0]   num_spheres;
  logic [31:0]       rayorig_x;
  logic [31:0]       rayorig_y;
  logic [31:0]       rayorig_z;
  logic [31:0]       raydir_x;
  logic [31:0]       raydir_y;
  logic [31:0]       raydir_z;
  logic [ADDR_W-1:0] sph_addr;
  logic [127:0]      sph_data;
  logic              isect_start;
  logic              isect_calc_t0;
  logic [31:0]       isect_radius_sqr;
  logic [31:0]       isect_center_x;
  logic [31:0]       isect_center_y;
  logic [31:0]       isect_center_z;
  logic [31:0]       isect_orig_x;
  logic [31:0]       isect_orig_y;
  logic [31:0]       isect_orig_z;
  logic [31:0]       isect_dir_x;
  logic [31:0]       isect_dir_y;
  logic [31:0]       isect_dir_z;
  logic              isect_finish;
  logic [31:0]       isect_t0;
  logic              busy;
  logic              done;
  logic              hit;
  logic [ADDR_W-1:0] hit_index;
  logic [31:0]       hit_t;

  modport master (
    input  start, num_spheres,
    input  rayorig_x, rayorig_y, rayorig_z,
    input  raydir_x, raydir_y, raydir_z,
    output sph_addr,
    input  sph_data,
    output isect_start, isect_calc_t0,
    output isect_radius_sqr,
    output isect_center_x, isect_center_y, isect_center_z,
    output isect_orig_x, isect_orig_y, isect_orig_z,
    output isect_dir_x, isect_dir_y, isect_dir_z,
    input  isect_finish, isect_t0,
    output busy, done, hit, hit_index, hit_t
  );

  modport slave (
    output start, num_spheres,
    output rayorig_x, rayorig_y, rayorig_z,
    output raydir_x, raydir_y, raydir_z,
    input  sph_addr,
    output sph_data,
    input  isect_start, isect_calc_t0,
    input  isect_radius_sqr,
    input  isect_center_x, isect_center_y, isect_center_z,
    input  isect_orig_x, isect_orig_y, isect_orig_z,
    input  isect_dir_x, isect_dir_y, isect_dir_z,
    output isect_finish, isect_t0,
    input  busy, done, hit, hit_index, hit_t
  );
endinterface

// File: rtl/nearest_hit_scan.sv
// Walks a sphere table through an external intersection unit
// and keeps the nearest positive hit distance and its index.
module nearest_hit_scan #(
  parameter int MAX_SPHERES = 16,
  parameter int ADDR_W      = 4
) (
  input logic clk,
  input logic rst_n,
  nearest_hit_scan_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    ISSUE,
    WAIT,
    COMPARE,
    DONE
  } state_e;

  localparam logic [ADDR_W:0] MAX_N =
    (ADDR_W+1)'(MAX_SPHERES);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   num_q, num_d;
  logic [ADDR_W:0]   num_clamp;
  logic [ADDR_W:0]   idx_inc;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] hit_idx_q, hit_idx_d;
  logic              hit_q, hit_d;
  logic [31:0]       hit_t_q, hit_t_d;
  logic [31:0]       t0_q, t0_d;
  logic              t0_hit;
  logic [31:0]       ox_q, ox_d, oy_q, oy_d, oz_q, oz_d;
  logic [31:0]       dx_q, dx_d, dy_q, dy_d, dz_q, dz_d;
  logic [31:0]       rad_q, rad_d;
  logic [31:0]       cx_q, cx_d, cy_q, cy_d, cz_q, cz_d;

  assign num_clamp = (bus.num_spheres > MAX_N)
                   ? MAX_N : bus.num_spheres;
  assign idx_inc   = {1'b0, idx_q} + (ADDR_W+1)'(1);
  // zero is the unit's early-reject code, sign bit marks behind-origin
  assign t0_hit    = (t0_q != '0) && !t0_q[31];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      num_q     <= '0;
      idx_q     <= '0;
      hit_q     <= 1'b0;
      hit_idx_q <= '0;
      hit_t_q   <= '0;
      t0_q      <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      oz_q      <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      dz_q      <= '0;
      rad_q     <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      cz_q      <= '0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      idx_q     <= idx_d;
      hit_q     <= hit_d;
      hit_idx_q <= hit_idx_d;
      hit_t_q   <= hit_t_d;
      t0_q      <= t0_d;
      ox_q      <= ox_d;
      oy_q      <= oy_d;
      oz_q      <= oz_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      dz_q      <= dz_d;
      rad_q     <= rad_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      cz_q      <= cz_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    idx_d     = idx_q;
    hit_d     = hit_q;
    hit_idx_d = hit_idx_q;
    hit_t_d   = hit_t_q;
    t0_d      = t0_q;
    ox_d      = ox_q;
    oy_d      = oy_q;
    oz_d      = oz_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    dz_d      = dz_q;
    rad_d     = rad_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    cz_d      = cz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          num_d     = num_clamp;
          idx_d     = '0;
          hit_d     = 1'b0;
          hit_idx_d = '0;
          hit_t_d   = '0;
          ox_d      = bus.rayorig_x;
          oy_d      = bus.rayorig_y;
          oz_d      = bus.rayorig_z;
          dx_d      = bus.raydir_x;
          dy_d      = bus.raydir_y;
          dz_d      = bus.raydir_z;
          state_d   = (num_clamp == '0)
                    ? DONE : FETCH;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        rad_d   = bus.sph_data[127:96];
        cx_d    = bus.sph_data[95:64];
        cy_d    = bus.sph_data[63:32];
        cz_d    = bus.sph_data[31:0];
        state_d = ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (bus.isect_finish) begin
          t0_d    = bus.isect_t0;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        // strict less-than keeps the lower index on ties
        if (t0_hit && (!hit_q || t0_q < hit_t_q)) begin
          hit_d     = 1'b1;
          hit_t_d   = t0_q;
          hit_idx_d = idx_q;
        end
        if (idx_inc == num_q) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_inc[ADDR_W-1:0];
          state_d = FETCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.sph_addr         = idx_q;
  assign bus.isect_start      = (state_q == ISSUE);
  assign bus.isect_calc_t0    = 1'b1;
  assign bus.isect_radius_sqr = rad_q;
  assign bus.isect_center_x   = cx_q;
  assign bus.isect_center_y   = cy_q;
  assign bus.isect_center_z   = cz_q;
  assign bus.isect_orig_x     = ox_q;
  assign bus.isect_orig_y     = oy_q;
  assign bus.isect_orig_z     = oz_q;
  assign bus.isect_dir_x      = dx_q;
  assign bus.isect_dir_y      = dy_q;
  assign bus.isect_dir_z      = dz_q;
  assign bus.busy             = (state_q != IDLE);
  assign bus.done             = (state_q == DONE);
  assign bus.hit              = hit_q;
  assign bus.hit_index        = hit_idx_q;
  assign bus.hit_t            = hit_t_q;

endmodule

// File: tb/tb_nearest_hit_scan.sv
// Directed and randomized scans of nearest_hit_scan against a
// table-driven reference of the nearest positive hit.
module tb_nearest_hit_scan;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  nearest_hit_scan_if #(.ADDR_W(4)) bus();

  nearest_hit_scan #(
    .MAX_SPHERES(16),
    .ADDR_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] mem [16];
  logic [31:0]  t0_tab [16];
  int           dly_tab [16];
  int           n_issue = 0;
  logic         fin;
  logic         pend;
  int           rem;
  logic [31:0]  ox, dz;

  always @(posedge clk) bus.sph_data <= mem[bus.sph_addr];

  // sphere id rides in center_x[3:0]; t0 and latency come from tables
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0;
      fin  <= 1'b0;
      rem  <= 0;
    end else begin
      fin <= 1'b0;
      if (bus.isect_start) begin
        n_issue      <= n_issue + 1;
        bus.isect_t0 <= t0_tab[bus.isect_center_x[3:0]];
        if (dly_tab[bus.isect_center_x[3:0]] <= 1) begin
          fin <= 1'b1;
        end else begin
          pend <= 1'b1;
          rem  <= dly_tab[bus.isect_center_x[3:0]] - 1;
        end
      end else if (pend) begin
        rem <= rem - 1;
        if (rem == 1) begin
          fin  <= 1'b1;
          pend <= 1'b0;
        end
      end
    end
  end
  assign bus.isect_finish = fin;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fill_table();
    logic [31:0] cx;
    for (int i = 0; i < 16; i++) begin
      cx      = $urandom();
      cx[3:0] = i[3:0];
      mem[i]  = {$urandom(), cx, $urandom(), $urandom()};
      t0_tab[i]  = 32'h0;
      dly_tab[i] = 1;
    end
  endtask

  function automatic void ref_scan(input int n,
                                   output logic h,
                                   output logic [31:0] hi,
                                   output logic [31:0] ht,
                                   output int m,
                                   output int lat);
    m   = (n > 16) ? 16 : n;
    h   = 1'b0;
    hi  = 0;
    ht  = 0;
    lat = 1;
    for (int i = 0; i < m; i++) begin
      lat += 4 + dly_tab[i];
      if (t0_tab[i] != 0 && t0_tab[i] < 32'h8000_0000) begin
        if (!h || t0_tab[i] < ht) begin
          h  = 1'b1;
          ht = t0_tab[i];
          hi = i;
        end
      end
    end
  endfunction

  task automatic run_scan(input string tag,
                          input int n,
                          input int poke);
    logic        eh;
    logic [31:0] ehi, eht;
    int          m, lat, cyc, base;
    ref_scan(n, eh, ehi, eht, m, lat);
    ox = $urandom();
    dz = $urandom();
    @(posedge clk); #1;
    base              = n_issue;
    bus.start         = 1'b1;
    bus.num_spheres   = 5'(n);
    bus.rayorig_x     = ox;
    bus.rayorig_y     = $urandom();
    bus.rayorig_z     = $urandom();
    bus.raydir_x      = $urandom();
    bus.raydir_y      = $urandom();
    bus.raydir_z      = dz;
    @(posedge clk); #1;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 2000) begin
      bus.start = (cyc == poke);
      if (cyc == poke) begin
        bus.num_spheres = 5'd2;
        bus.rayorig_x   = ~ox;
        bus.raydir_z    = ~dz;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    check({tag, ".done_seen"}, 32'(bus.done), 32'd1);
    check({tag, ".latency"}, cyc, lat);
    check({tag, ".busy_at_done"}, 32'(bus.busy), 32'd1);
    check({tag, ".hit"}, 32'(bus.hit), 32'(eh));
    check({tag, ".hit_index"}, 32'(bus.hit_index), ehi);
    check({tag, ".hit_t"}, bus.hit_t, eht);
    check({tag, ".issues"}, n_issue - base, m);
    check({tag, ".orig_x"}, bus.isect_orig_x, ox);
    check({tag, ".dir_z"}, bus.isect_dir_z, dz);
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, ".busy_after"}, 32'(bus.busy), 32'd0);
    check({tag, ".hit_hold"}, bus.hit_t, eht);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc, base, sel;
    logic [31:0] pool;
    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.num_spheres = '0;
    bus.rayorig_x   = '0;
    bus.rayorig_y   = '0;
    bus.rayorig_z   = '0;
    bus.raydir_x    = '0;
    bus.raydir_y    = '0;
    bus.raydir_z    = '0;
    fill_table();
    #22;
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.done", 32'(bus.done), 32'd0);
    check("rst.hit", 32'(bus.hit), 32'd0);
    check("rst.hit_t", bus.hit_t, 32'd0);
    check("rst.sph_addr", 32'(bus.sph_addr), 32'd0);
    check("rst.isect_start", 32'(bus.isect_start), 32'd0);
    check("rst.calc_t0", 32'(bus.isect_calc_t0), 32'd1);
    check("rst.orig_x", bus.isect_orig_x, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_scan("zero", 0, 0);

    fill_table();
    t0_tab[0] = 32'h0005_0000; dly_tab[0] = 3;
    t0_tab[1] = 32'h0003_0000; dly_tab[1] = 1;
    t0_tab[2] = 32'h0004_0000; dly_tab[2] = 2;
    run_scan("three", 3, 0);

    fill_table();
    t0_tab[0] = 32'h0;
    t0_tab[1] = 32'h8000_1000; dly_tab[1] = 4;
    run_scan("miss", 2, 0);

    fill_table();
    t0_tab[0] = 32'h0002_0000; dly_tab[0] = 2;
    t0_tab[1] = 32'h0002_0000; dly_tab[1] = 1;
    run_scan("tie", 2, 0);

    fill_table();
    for (int i = 0; i < 4; i++) begin
      dly_tab[i] = 6;
      t0_tab[i]  = 32'h0001_0000 * (5 - i);
    end
    run_scan("poke", 4, 5);

    fill_table();
    for (int i = 0; i < 16; i++) begin
      t0_tab[i]  = 32'h0010_0000 - 32'(i);
      dly_tab[i] = 1 + (i % 3);
    end
    run_scan("clamp", 20, 0);

    for (int r = 0; r < 6; r++) begin
      fill_table();
      for (int i = 0; i < 16; i++) begin
        sel  = $urandom_range(0, 3);
        pool = $urandom();
        unique case (sel)
          0: t0_tab[i] = 32'h0;
          1: t0_tab[i] = {1'b1, pool[30:0]};
          2: t0_tab[i] = 32'($urandom_range(1, 3)) << 16;
          default: t0_tab[i] = {1'b0, pool[30:0]};
        endcase
        dly_tab[i] = $urandom_range(1, 5);
      end
      run_scan($sformatf("rand%0d", r),
               $urandom_range(1, 16), 0);
    end

    fill_table();
    t0_tab[0] = 32'h0001_0000; dly_tab[0] = 2;
    t0_tab[1] = 32'h0000_8000; dly_tab[1] = 20;
    t0_tab[2] = 32'h0000_4000; dly_tab[2] = 1;
    @(posedge clk); #1;
    base            = n_issue;
    bus.start       = 1'b1;
    bus.num_spheres = 5'd3;
    bus.rayorig_x   = 32'h1234_5678;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 0;
    while ((n_issue - base) < 2 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("arst.issued2", n_issue - base, 2);
    @(posedge clk); #1;
    check("arst.busy_pre", 32'(bus.busy), 32'd1);
    check("arst.hit_pre", 32'(bus.hit), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.busy", 32'(bus.busy), 32'd0);
    check("arst.hit", 32'(bus.hit), 32'd0);
    check("arst.hit_t", bus.hit_t, 32'd0);
    check("arst.sph_addr", 32'(bus.sph_addr), 32'd0);
    check("arst.center_x", bus.isect_center_x, 32'd0);
    check("arst.radius", bus.isect_radius_sqr, 32'd0);
    check("arst.orig_x", bus.isect_orig_x, 32'd0);
    check("arst.calc_t0", 32'(bus.isect_calc_t0), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    dly_tab[1] = 3;
    run_scan("arst.rerun", 3, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nearest_hit_scan.md
NEAREST_HIT_SCAN -- requirements
Module: nearest_hit_scan

Interface
REQ-001 Parameters SHALL be: MAX_SPHERES, 16, upper bound on spheres per scan; ADDR_W, 4, sphere-table address width.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous and active-low; one clock, no other reset.
REQ-004 start  input  1  one-cycle request to begin a scan; ignored unless idle.
REQ-005 num_spheres  input  ADDR_W+1  number of table entries to scan (0..MAX_SPHERES), sampled on accepted start.
REQ-006 rayorig_x/y/z, raydir_x/y/z  input  32 each  ray in 16.16 fixed point, sampled on accepted start.
REQ-007 sph_addr  output  ADDR_W  sphere-table read address.
REQ-008 sph_data  input  128  table word {radius_sqr, centerx, centery, centerz}, MSB first, valid one cycle after sph_addr.
REQ-009 isect_start  output  1  start pulse to the sphere-intersection unit.
REQ-010 isect_calc_t0  output  1  tied 1: distance always requested.
REQ-011 isect_radius_sqr, isect_center_x/y/z, isect_orig_x/y/z, isect_dir_x/y/z  output  32 each  registered operands to the intersection unit.
REQ-012 isect_finish  input  1  intersection-unit finish flag.
REQ-013 isect_t0  input  32  intersection-unit distance, 16.16.
REQ-014 busy  output  1  high from accepted start until done.
REQ-015 done  output  1  one-cycle pulse, scan complete.
REQ-016 hit  output  1  at least one sphere hit; valid from done until next accepted start.
REQ-017 hit_index  output  ADDR_W  index of nearest hit sphere.
REQ-018 hit_t  output  32  distance to nearest hit, 16.16.

Function
REQ-019 FSM states SHALL be IDLE, FETCH, LOAD, ISSUE, WAIT, COMPARE, DONE.
REQ-020 IDLE: start=1 captures ray operands and num_spheres, clears idx, hit, hit_index, hit_t; go FETCH, or DONE if num_spheres=0.
REQ-021 FETCH: sph_addr=idx (held stable in FETCH and LOAD); go LOAD.
REQ-022 LOAD: capture sph_data into the isect operand registers; go ISSUE.
REQ-023 ISSUE: isect_start=1 for exactly this cycle; go WAIT. isect_start SHALL be 0 in every other state.
REQ-024 WAIT: isect_finish is sampled from the first WAIT cycle on; on isect_finish=1 capture isect_t0 and go COMPARE; no timeout.
REQ-025 COMPARE: sphere counts as hit iff captured t0 != 0 and t0[31]=0 (a 0 result means miss/early reject).
REQ-026 COMPARE: on a hit with (hit=0 or t0 < hit_t, unsigned), update hit=1, hit_t=t0, hit_index=idx; ties keep the lower index.
REQ-027 COMPARE: if idx+1 = num_spheres go DONE, else idx increments and go FETCH.
REQ-028 DONE: done=1 one cycle, busy drops; go IDLE. hit, hit_index, hit_t hold until next accepted start.
REQ-029 busy SHALL be 1 in all states except IDLE; start while busy is ignored with no effect.
REQ-030 Per-sphere cost SHALL be 4 + W cycles, W = WAIT-state cycles; total scan = N*(4+W_avg) + 2 cycles incl. IDLE accept and DONE.
REQ-031 Operand outputs SHALL be registered and constant from LOAD through WAIT.
REQ-032 num_spheres > MAX_SPHERES SHALL be clamped to MAX_SPHERES.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE and zero every output and internal register, including mid-scan; isect_calc_t0 stays 1.
REQ-034 After rst_n rises, the first start SHALL be accepted on the first clk edge.

Verification
REQ-035 num_spheres=0, start -> done 1 cycle after acceptance, hit=0, hit_t=0, no isect_start.
REQ-036 3 spheres, model returns t0 = 0x00050000, 0x00030000, 0x00040000 -> hit=1, hit_index=1, hit_t=0x00030000, three isect_start pulses.
REQ-037 2 spheres, model returns t0=0 and t0=0x80001000 -> hit=0, hit_index=0, hit_t=0.
REQ-038 2 spheres, both t0=0x00020000 -> hit_index=0 (tie keeps lower index).
REQ-039 rst_n pulsed low during WAIT of sphere 2 -> busy=0, all outputs 0 asynchronously; new start runs full scan correctly.
REQ-040 start re-asserted during WAIT -> ignored, scan result unchanged; model with fixed 6-cycle finish delay, 4 spheres -> done at cycle 4*10+2 after start.
